// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CPB-1 while enabled and flags the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CPB = 4
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

    logic [CW-1:0] cnt_q;

    assign wrap = en && (cnt_q == CW'(CPB - 1));

    always_ff @(posedge CLK_I) begin
        if (RST_I || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= wrap ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// 8N1 serial framer with peer flow-control hold and a registered passthrough channel.
//  state | meaning
//  IDLE  | line idle (or passthrough of TX2_I), ready for a byte
//  START | start bit (0) for CPB cycles
//  DATA  | eight data bits, LSB first, CPB cycles each
//  STOP  | stop bit (1) for CPB cycles, DONE_O on its last cycle
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] DATA_I,
    input  logic       VALID_I,
    output logic       READY_O,
    input  logic       PAUSE_I,
    input  logic       CHANNEL_I,
    input  logic       TX2_I,
    output logic       TX_O,
    output logic       BUSY_O,
    output logic       DONE_O
);
    localparam int CPB = CLK_RATE / BAUD_RATE;

    if (CPB < 2) begin : g_cpb_check
        $error("uart_frame_tx: CLK_RATE/BAUD_RATE must be at least 2");
    end

    tx_state_t  state_q, state_d;
    logic [7:0] data_q;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d;
    logic       chan_q;
    logic       fire;
    logic       wrap;

    uart_baud_cnt #(.CPB(CPB)) u_baud_cnt (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .en    (state_q != IDLE),
        .clr   (state_q == IDLE),
        .wrap  (wrap)
    );

    assign READY_O = (state_q == IDLE) && !PAUSE_I && !chan_q && !RST_I;
    assign fire    = VALID_I && READY_O;
    assign BUSY_O  = (state_q != IDLE);
    assign DONE_O  = (state_q == STOP) && wrap;
    assign TX_O    = tx_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                // Line value for the next cycle reflects the channel chan_q is about to take.
                tx_d = CHANNEL_I ? TX2_I : 1'b1;
                if (fire) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_d];
                    end
                end
            end
            STOP: begin
                if (wrap) begin
                    state_d = IDLE;
                    tx_d    = CHANNEL_I ? TX2_I : 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            chan_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            if (state_d == IDLE) begin
                chan_q <= CHANNEL_I;
            end
            if (fire) begin
                data_q <= DATA_I;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboarded bench for uart_frame_tx at CPB=4: framing, back-to-back, pause, passthrough, reset abort.
module tb_uart_frame_tx;
    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic [7:0] DATA_I = '0;
    logic       VALID_I = 1'b0;
    logic       READY_O;
    logic       PAUSE_I = 1'b0;
    logic       CHANNEL_I = 1'b0;
    logic       TX2_I = 1'b0;
    logic       TX_O;
    logic       BUSY_O;
    logic       DONE_O;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;
    int prev_start = 0;
    int aborts = 0;
    logic expect_abort = 1'b0;
    logic [7:0] sb[$];

    uart_frame_tx #(.CLK_RATE(1_000_000), .BAUD_RATE(250_000)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .DATA_I    (DATA_I),
        .VALID_I   (VALID_I),
        .READY_O   (READY_O),
        .PAUSE_I   (PAUSE_I),
        .CHANNEL_I (CHANNEL_I),
        .TX2_I     (TX2_I),
        .TX_O      (TX_O),
        .BUSY_O    (BUSY_O),
        .DONE_O    (DONE_O)
    );

    always #5 CLK_I = ~CLK_I;
    always @(posedge CLK_I) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Waits for READY_O with VALID_I high, records the byte, returns at frame cycle 1.
    task automatic hs(input logic [7:0] b, output int waited);
        waited = 0;
        DATA_I  = b;
        VALID_I = 1'b1;
        #1;
        while (!READY_O && waited < 2000) begin
            @(negedge CLK_I);
            #1;
            waited++;
        end
        chk("hs_ready", READY_O, 1'b1);
        if (READY_O) sb.push_back(b);
        @(negedge CLK_I);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY_O && n < 100) begin
            @(negedge CLK_I);
            n++;
        end
        chk("idle_timeout", BUSY_O, 1'b0);
    endtask

    // Frame monitor: checks every cycle of each frame against the popped expected byte.
    initial begin
        logic [7:0] eb;
        int idx;
        logic eb_bit;
        forever begin
            @(negedge CLK_I);
            if (BUSY_O === 1'b1) begin
                prev_start = last_start;
                last_start = cyc;
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                eb = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                for (int c = 1; c <= 40; c++) begin
                    if (BUSY_O !== 1'b1) begin
                        aborts++;
                        chk("frame_abort", 1'b1, expect_abort);
                        chk("abort_tx", TX_O, 1'b1);
                        chk("abort_done", DONE_O, 1'b0);
                        break;
                    end
                    idx = (c - 1) / 4;
                    if (idx == 0) eb_bit = 1'b0;
                    else if (idx == 9) eb_bit = 1'b1;
                    else eb_bit = eb[idx-1];
                    chk("frame_tx", TX_O, eb_bit);
                    chk("frame_done", DONE_O, (c == 40));
                    if (c < 40) @(negedge CLK_I);
                end
            end else begin
                chk("idle_done", DONE_O, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic prev;

        // reset state
        repeat (2) @(negedge CLK_I);
        chk("rst_tx", TX_O, 1'b1);
        chk("rst_busy", BUSY_O, 1'b0);
        chk("rst_done", DONE_O, 1'b0);
        chk("rst_ready", READY_O, 1'b0);
        RST_I = 1'b0;
        #1;
        chk("post_rst_ready", READY_O, 1'b1);
        @(negedge CLK_I);

        // single 0xA5 frame
        hs(8'hA5, w);
        VALID_I = 1'b0;
        chk("a5_ready_low", READY_O, 1'b0);
        chk("a5_busy", BUSY_O, 1'b1);
        wait_idle();

        // back-to-back 0x00 then 0xFF with VALID_I held
        hs(8'h00, w);
        hs(8'hFF, w);
        chk("b2b_wait", w, 40);
        #1;
        chk("b2b_ready_once", READY_O, 1'b0);
        VALID_I = 1'b0;
        wait_idle();
        chk("b2b_spacing", last_start - prev_start, 41);

        // pause raised mid-frame
        hs(8'h5A, w);
        VALID_I = 1'b0;
        repeat (9) @(negedge CLK_I);
        PAUSE_I = 1'b1;
        DATA_I  = 8'h77;
        VALID_I = 1'b1;
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            chk("pause_ready", READY_O, 1'b0);
            chk("pause_tx", TX_O, 1'b1);
            chk("pause_busy", BUSY_O, 1'b0);
            @(negedge CLK_I);
        end
        VALID_I = 1'b0;
        PAUSE_I = 1'b0;
        #1;
        chk("unpause_ready", READY_O, 1'b1);
        @(negedge CLK_I);

        // channel switch mid-frame, passthrough afterwards
        hs(8'hC3, w);
        VALID_I = 1'b0;
        for (int c = 2; c <= 54; c++) begin
            prev = TX2_I;
            @(negedge CLK_I);
            if (c >= 42) begin
                chk("pass_tx", TX_O, prev);
                chk("pass_ready", READY_O, 1'b0);
                chk("pass_busy", BUSY_O, 1'b0);
            end
            TX2_I = ((c % 3) == 0);
            if (c == 15) CHANNEL_I = 1'b1;
            if (c == 44) begin
                DATA_I  = 8'h11;
                VALID_I = 1'b1;
            end
        end
        VALID_I   = 1'b0;
        CHANNEL_I = 1'b0;
        TX2_I     = 1'b0;
        repeat (2) @(negedge CLK_I);
        chk("unpass_tx", TX_O, 1'b1);
        chk("unpass_ready", READY_O, 1'b1);

        // reset at frame cycle 20
        expect_abort = 1'b1;
        hs(8'h99, w);
        VALID_I = 1'b0;
        repeat (19) @(negedge CLK_I);
        RST_I = 1'b1;
        #1;
        chk("rst_hold_ready", READY_O, 1'b0);
        @(negedge CLK_I);
        chk("rst_mid_tx", TX_O, 1'b1);
        chk("rst_mid_busy", BUSY_O, 1'b0);
        chk("rst_mid_done", DONE_O, 1'b0);
        RST_I = 1'b0;
        @(negedge CLK_I);
        expect_abort = 1'b0;
        hs(8'h3C, w);
        VALID_I = 1'b0;
        wait_idle();
        repeat (3) @(negedge CLK_I);

        chk("abort_count", aborts, 1);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
